echo_req_arbiter: RTL

- Round-robin arbiter that shares one Echo request/indication channel among NUM_REQ requesters.
- Grants at most one requester per cycle onto echoReq and records the requester ID in an in-order tag FIFO.
- Routes each returning ind_echo beat back to the requester at the tag FIFO head.
- Sits between the per-client request ports and a single Echo instance; the Echo is in-order, one response per request.

---
 rtl/echo_req_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/echo_req_arbiter.sv
// echo_req_arbiter: round-robin sharing of one in-order Echo channel with tag-FIFO response routing
module echo_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic [NUM_REQ-1:0]          req_pend,
  output logic [NUM_REQ-1:0]          req__RDY,
  input  logic [NUM_REQ-1:0]          req__ENA,
  input  logic [NUM_REQ*DATA_W-1:0]   req_v,
  input  logic                        echo_echoReq__RDY,
  output logic                        echo_echoReq__ENA,
  output logic [DATA_W-1:0]           echo_echoReq_v,
  input  logic                        ind_echo__ENA,
  input  logic [DATA_W-1:0]           ind_echo_v,
  output logic [NUM_REQ-1:0]          resp__ENA,
  output logic [DATA_W-1:0]           resp_v,
  output logic [$clog2(TAG_DEPTH):0]  outstanding,
  output logic                        orphan_err,
  output logic                        proto_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(TAG_DEPTH) + 1;
  logic [IW-1:0] rr_ptr, gnt_id, idx, head_id;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] tags [TAG_DEPTH];
  logic found, can_issue, issue, pop, empty;
  assign outstanding = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign can_issue = echo_echoReq__RDY & ~outstanding[PW-1] & nRST;
  assign head_id = tags[rd_ptr[PW-2:0]];
  // first pending requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    gnt_id = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_pend[idx]) begin
        found = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign req__RDY = (can_issue && found) ? NUM_REQ'(1) << gnt_id : '0;
  assign issue = |(req__ENA & req__RDY);
  assign echo_echoReq__ENA = issue;
  assign echo_echoReq_v = issue ? req_v[gnt_id*DATA_W +: DATA_W] : '0;
  assign pop = nRST & ind_echo__ENA & ~empty;
  assign resp__ENA = pop ? NUM_REQ'(1) << head_id : '0;
  assign resp_v = pop ? ind_echo_v : '0;
  // tag storage needs no reset; only the pointers define validity
  always_ff @(posedge CLK) begin
    if (issue) tags[wr_ptr[PW-2:0]] <= gnt_id;
  end
  // pointers, round-robin priority and sticky error flags
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      orphan_err <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (ind_echo__ENA && empty) orphan_err <= 1'b1;
      if (|(req__ENA & ~req__RDY)) proto_err <= 1'b1;
    end
  end
endmodule
